phy_rx_sp: RTL and testbench
============================

# phy_rx_sp

Receive-side serial-to-parallel stage of the PHY: consumes the two serial lanes produced by `phy_tx` (`salida_ser_lane_0/1`) and rebuilds the 8-bit words.
- Each lane independently finds byte alignment by hunting for the 0xBC idle comma, then declares itself active after four consecutive aligned commas.
- Once active, it delivers non-comma bytes with a valid level and a one-cycle strobe.
- Everything runs on the bit clock `clk_8f`; downstream consumers use the strobe to take each byte exactly once.

## Interface
Parameters:
- `BC` — default 8'hBC — comma/idle symbol transmitted by `phy_tx` when the lane has no valid data.
- `NUM_BC` — default 4 — consecutive aligned commas needed to reach active.

Ports:
- `clk_8f` — in — 1 — bit clock, rising-edge.
- `reset` — in — 1 — asynchronous, active-low.
- `ser_lane_0` — in — 1 — serial lane 0, MSB first.
- `ser_lane_1` — in — 1 — serial lane 1, MSB first.
- `salida_0` — out — 8 — last received data byte, lane 0.
- `validout_0` — out — 1 — `salida_0` holds a data (non-comma) byte for the current 8-cycle slot.
- `stb_0` — out — 1 — one-cycle pulse when a new data byte is loaded into `salida_0`.
- `active_0` — out — 1 — lane 0 aligned and synchronized.
- `salida_1`, `validout_1`, `stb_1`, `active_1` — out — 8/1/1/1 — same meanings for lane 1.

## Operation
Per lane:
- **Shift register.** `sr[7:0]` shifts on every edge: `sr <= {sr[6:0], ser}`. All byte checks use `nxt = {sr[6:0], ser}`, the word completed on the current edge.
- **Bit counter.** `bitcnt[2:0]`. A byte boundary is an edge where `bitcnt == 7`; `bitcnt` wraps 7→0.
- **BC counter.** `bccnt` is sized for `NUM_BC`.

States:
- **BUSCANDO** (reset state)
  - Every edge: if `nxt == BC`, set `bitcnt = 0`, `bccnt = 1`, go to SINCRONIZANDO.
  - Otherwise `bitcnt` is don't-care.
- **SINCRONIZANDO**
  - `bitcnt` increments every edge.
  - At a byte boundary with `nxt == BC`: `bccnt++`. When `bccnt` reaches `NUM_BC`, go to ACTIVO.
  - At a byte boundary with `nxt != BC`: `bccnt = 0`, go to BUSCANDO.
- **ACTIVO**
  - `bitcnt` increments every edge.
  - At a byte boundary with `nxt != BC`: `salida <= nxt`, `validout <= 1`, `stb <= 1`.
  - At a byte boundary with `nxt == BC`: `salida` holds its value, `validout <= 0`, `stb <= 0`.
  - On all other edges, `stb <= 0`.
  - ACTIVO is left only by reset. Misalignment after lock is not detected.
- `active` equals 1 exactly when the lane is in ACTIVO.

Reset (`reset == 0`, asynchronous):
- `sr = 0`, `bitcnt = 0`, `bccnt = 0`, state BUSCANDO.
- All outputs 0: `salida = 8'h00`, `validout = 0`, `stb = 0`, `active = 0`.
- Reset asserted mid-byte discards the partial byte. Re-lock needs `NUM_BC` fresh commas.

The two lanes share no state and are fully independent (different alignment offsets, different lock times).

## Timing
- Comma hunt: `active` rises on the edge that captures the last bit of the `NUM_BC`-th aligned comma. There are no extra pipeline stages.
- Data latency: `salida`, `validout` and `stb` update on the same edge that samples the byte's LSB. Latency is 0 cycles after the last bit.
- `stb` is high for exactly 1 cycle per data byte. `validout` and `salida` are stable for the following 8 cycles, until the next boundary.
- Back-to-back data bytes give `stb` pulses every 8 cycles, with `validout` held continuously at 1.
- A comma match inside BUSCANDO is bit-granular: a match is possible on any edge, including the first 8 edges after reset, once 8 real bits have shifted in.

## Structure
- Shared package/header: `BC` symbol, `NUM_BC`, and the state encodings (BUSCANDO=0, SINCRONIZANDO=1, ACTIVO=2, 2-bit).
- Sub-module `sp_lane`: one lane, holding the shift register, counters, FSM and output registers.
- `phy_rx_sp` instantiates `sp_lane` twice and contains no other logic.

## Test plan
- **Reset values:** `reset` low for 3 cycles, arbitrary serial input → all outputs 0. Release reset, drive the line constantly at 0 → `active` stays 0 indefinitely.
- **Offset lock:** lane 0 sends 3 junk bits (101), then 0xBC ×4 → `active_0` rises on the edge of the 32nd bit after the junk; `validout_0` and `stb_0` stay 0 throughout.
- **Data delivery:** after lock, send 0x5A then 0xBC → on the 0x5A LSB edge, `salida_0 = 0x5A`, `validout_0 = 1`, `stb_0` high for 1 cycle. On the 0xBC boundary, `validout_0 = 0` and `salida_0` stays 0x5A.
- **Broken hunt:** send 0xBC ×3, 0x00, then 0xBC ×4 → `active` stays 0 through the 0x00 byte and rises only after the second run.
- **Independent lanes:** lane 0 at offset 0, lane 1 at offset 5, both send 0xBC ×4 then 0x11/0x22 → `active_0` and `active_1` rise 5 cycles apart; `salida_0 = 0x11`, `salida_1 = 0x22`; the `stb` pulses are 5 cycles apart.
- **Reset mid-operation:** assert `reset` mid-byte while ACTIVO → outputs clear immediately. After release, data bytes are ignored until 4 new commas arrive.

Source files
------------

// File: rtl/phy_rx_sp_pkg.sv
// Shared constants and lane FSM encoding for the PHY receive serial-to-parallel stage.
package phy_rx_sp_pkg;

  localparam logic [7:0] BC_SYM     = 8'hBC;
  localparam int         NUM_BC_DEF = 4;

  typedef enum logic [1:0] {
    BUSCANDO      = 2'd0,
    SINCRONIZANDO = 2'd1,
    ACTIVO        = 2'd2
  } lane_state_e;

endpackage

// File: rtl/phy_rx_sp_lane.sv
// One receive lane: comma hunt, alignment lock and byte delivery on the bit clock.
module sp_lane
  import phy_rx_sp_pkg::*;
#(
  parameter logic [7:0] BC     = BC_SYM,
  parameter int         NUM_BC = NUM_BC_DEF
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       ser,
  output logic [7:0] salida,
  output logic       validout,
  output logic       stb,
  output logic       active
);

  localparam int CW = $clog2(NUM_BC + 1);
  localparam logic [CW-1:0] BC_LAST = CW'(NUM_BC - 1);

  lane_state_e   state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [CW-1:0] bccnt_q, bccnt_d;
  logic [7:0]    salida_q, salida_d;
  logic          validout_q, validout_d;
  logic          stb_q, stb_d;

  logic [7:0]    nxt;
  logic          boundary;
  logic          is_bc;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q    <= BUSCANDO;
      sr_q       <= 8'h00;
      bitcnt_q   <= 3'd0;
      bccnt_q    <= '0;
      salida_q   <= 8'h00;
      validout_q <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      bccnt_q    <= bccnt_d;
      salida_q   <= salida_d;
      validout_q <= validout_d;
      stb_q      <= stb_d;
    end
  end

  // All decisions look at the word completed by the bit arriving on this edge.
  always_comb begin
    nxt        = {sr_q[6:0], ser};
    boundary   = (bitcnt_q == 3'd7);
    is_bc      = (nxt == BC);
    sr_d       = nxt;
    bitcnt_d   = bitcnt_q + 3'd1;
    bccnt_d    = bccnt_q;
    state_d    = state_q;
    salida_d   = salida_q;
    validout_d = validout_q;
    stb_d      = 1'b0;

    unique case (state_q)
      BUSCANDO: begin
        bitcnt_d = bitcnt_q;
        if (is_bc) begin
          bitcnt_d = 3'd0;
          bccnt_d  = CW'(1);
          state_d  = (NUM_BC <= 1) ? ACTIVO : SINCRONIZANDO;
        end
      end
      SINCRONIZANDO: begin
        if (boundary) begin
          if (is_bc) begin
            bccnt_d = bccnt_q + CW'(1);
            if (bccnt_q == BC_LAST) state_d = ACTIVO;
          end else begin
            bccnt_d = '0;
            state_d = BUSCANDO;
          end
        end
      end
      ACTIVO: begin
        if (boundary) begin
          if (!is_bc) begin
            salida_d   = nxt;
            validout_d = 1'b1;
            stb_d      = 1'b1;
          end else begin
            validout_d = 1'b0;
          end
        end
      end
      default: state_d = BUSCANDO;
    endcase
  end

  assign salida   = salida_q;
  assign validout = validout_q;
  assign stb      = stb_q;
  assign active   = (state_q == ACTIVO);

endmodule

// File: rtl/phy_rx_sp.sv
// Two independent receive lanes rebuilding bytes from the phy_tx serial outputs.
module phy_rx_sp
  import phy_rx_sp_pkg::*;
#(
  parameter logic [7:0] BC     = BC_SYM,
  parameter int         NUM_BC = NUM_BC_DEF
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       ser_lane_0,
  input  logic       ser_lane_1,
  output logic [7:0] salida_0,
  output logic       validout_0,
  output logic       stb_0,
  output logic       active_0,
  output logic [7:0] salida_1,
  output logic       validout_1,
  output logic       stb_1,
  output logic       active_1
);

  sp_lane #(.BC(BC), .NUM_BC(NUM_BC)) u_lane_0 (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .ser      (ser_lane_0),
    .salida   (salida_0),
    .validout (validout_0),
    .stb      (stb_0),
    .active   (active_0)
  );

  sp_lane #(.BC(BC), .NUM_BC(NUM_BC)) u_lane_1 (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .ser      (ser_lane_1),
    .salida   (salida_1),
    .validout (validout_1),
    .stb      (stb_1),
    .active   (active_1)
  );

endmodule

// File: tb/tb_phy_rx_sp.sv
// Self-checking bench for phy_rx_sp: directed test-plan steps plus random streams vs a bit-index model.
module tb_phy_rx_sp;

  localparam logic [7:0] BC     = 8'hBC;
  localparam int         NUM_BC = 4;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic       ser_lane_0;
  logic       ser_lane_1;
  logic [7:0] salida_0;
  logic       validout_0;
  logic       stb_0;
  logic       active_0;
  logic [7:0] salida_1;
  logic       validout_1;
  logic       stb_1;
  logic       active_1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise0, rise1, stb0cyc, stb1cyc;

  // Reference model: each lane remembers the index of the bit where a comma was first
  // found, and treats every 8th bit after that as a byte boundary.
  logic [7:0] m_win    [2];
  int         m_pos    [2];
  int         m_anchor [2];
  int         m_commas [2];
  bit         m_found  [2];
  bit         m_locked [2];
  logic [7:0] m_sal    [2];
  logic       m_val    [2];
  logic       m_stb    [2];

  bit q0[$];
  bit q1[$];

  always #5 clk_8f = ~clk_8f;

  phy_rx_sp dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .ser_lane_0 (ser_lane_0),
    .ser_lane_1 (ser_lane_1),
    .salida_0   (salida_0),
    .validout_0 (validout_0),
    .stb_0      (stb_0),
    .active_0   (active_0),
    .salida_1   (salida_1),
    .validout_1 (validout_1),
    .stb_1      (stb_1),
    .active_1   (active_1)
  );

  function automatic void modelReset();
    for (int l = 0; l < 2; l++) begin
      m_win[l]    = 8'h00;
      m_pos[l]    = 0;
      m_anchor[l] = 0;
      m_commas[l] = 0;
      m_found[l]  = 1'b0;
      m_locked[l] = 1'b0;
      m_sal[l]    = 8'h00;
      m_val[l]    = 1'b0;
      m_stb[l]    = 1'b0;
    end
  endfunction

  function automatic void modelStep(int l, logic b);
    int n;
    n = m_pos[l];
    m_pos[l] = m_pos[l] + 1;
    m_win[l] = {m_win[l][6:0], b};
    m_stb[l] = 1'b0;
    if (!m_found[l]) begin
      if (m_win[l] == BC) begin
        m_found[l]  = 1'b1;
        m_anchor[l] = n;
        m_commas[l] = 1;
        if (m_commas[l] >= NUM_BC) m_locked[l] = 1'b1;
      end
    end else if (((n - m_anchor[l]) % 8) == 0) begin
      if (m_locked[l]) begin
        if (m_win[l] != BC) begin
          m_sal[l] = m_win[l];
          m_val[l] = 1'b1;
          m_stb[l] = 1'b1;
        end else begin
          m_val[l] = 1'b0;
        end
      end else if (m_win[l] == BC) begin
        m_commas[l] = m_commas[l] + 1;
        if (m_commas[l] >= NUM_BC) m_locked[l] = 1'b1;
      end else begin
        m_found[l]  = 1'b0;
        m_commas[l] = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("salida_0",   salida_0,   m_sal[0]);
    check("validout_0", {7'd0, validout_0}, {7'd0, m_val[0]});
    check("stb_0",      {7'd0, stb_0},      {7'd0, m_stb[0]});
    check("active_0",   {7'd0, active_0},   {7'd0, m_locked[0]});
    check("salida_1",   salida_1,   m_sal[1]);
    check("validout_1", {7'd0, validout_1}, {7'd0, m_val[1]});
    check("stb_1",      {7'd0, stb_1},      {7'd0, m_stb[1]});
    check("active_1",   {7'd0, active_1},   {7'd0, m_locked[1]});
  endtask

  task automatic applyStimulus(input logic b0, input logic b1);
    ser_lane_0 = b0;
    ser_lane_1 = b1;
    @(posedge clk_8f);
    cyc++;
    if (reset) begin
      modelStep(0, b0);
      modelStep(1, b1);
    end else begin
      modelReset();
    end
    #1;
    checkOutput();
    if (active_0 && rise0 < 0)  rise0   = cyc;
    if (active_1 && rise1 < 0)  rise1   = cyc;
    if (stb_0 && stb0cyc < 0)   stb0cyc = cyc;
    if (stb_1 && stb1cyc < 0)   stb1cyc = cyc;
  endtask

  task automatic pushBit(input int l, input bit b);
    if (l == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic pushByte(input int l, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) pushBit(l, v[i]);
  endtask

  task automatic runBits(input int n);
    bit b0, b1;
    for (int i = 0; i < n; i++) begin
      b0 = (q0.size() > 0) ? q0.pop_front() : 1'b0;
      b1 = (q1.size() > 0) ? q1.pop_front() : 1'b0;
      applyStimulus(b0, b1);
    end
  endtask

  task automatic runAll();
    runBits((q0.size() > q1.size()) ? q0.size() : q1.size());
  endtask

  // Reset is asserted between edges so its asynchronous effect is visible right away.
  task automatic resetPulse(input int cycles);
    q0.delete();
    q1.delete();
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput();
    for (int i = 0; i < cycles; i++) applyStimulus(1'($urandom), 1'($urandom));
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    ser_lane_0 = 1'b0;
    ser_lane_1 = 1'b0;
    rise0 = -1; rise1 = -1; stb0cyc = -1; stb1cyc = -1;
    modelReset();

    $display("[TB] reset values");
    for (int i = 0; i < 3; i++) applyStimulus(1'($urandom), 1'($urandom));
    check("reset_salida_0", salida_0, 8'h00);
    check("reset_active_1", {7'd0, active_1}, 8'h00);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);
    check("idle_zero_active_0", {7'd0, active_0}, 8'h00);

    $display("[TB] offset lock and data delivery");
    pushBit(0, 1'b1); pushBit(0, 1'b0); pushBit(0, 1'b1);
    for (int i = 0; i < 4; i++) pushByte(0, BC);
    runBits(34);
    check("lock_before_active_0", {7'd0, active_0}, 8'h00);
    check("lock_validout_0", {7'd0, validout_0}, 8'h00);
    runBits(1);
    check("lock_edge_active_0", {7'd0, active_0}, 8'h01);
    check("lock_edge_stb_0", {7'd0, stb_0}, 8'h00);
    pushByte(0, 8'h5A);
    pushByte(0, BC);
    runBits(8);
    check("data_salida_0", salida_0, 8'h5A);
    check("data_validout_0", {7'd0, validout_0}, 8'h01);
    check("data_stb_0", {7'd0, stb_0}, 8'h01);
    runBits(1);
    check("data_stb_drop_0", {7'd0, stb_0}, 8'h00);
    runBits(6);
    check("data_valid_hold_0", {7'd0, validout_0}, 8'h01);
    runBits(1);
    check("comma_validout_0", {7'd0, validout_0}, 8'h00);
    check("comma_salida_hold_0", salida_0, 8'h5A);

    $display("[TB] broken hunt");
    resetPulse(2);
    for (int i = 0; i < 3; i++) pushByte(0, BC);
    pushByte(0, 8'h00);
    runAll();
    check("broken_after_zero", {7'd0, active_0}, 8'h00);
    for (int i = 0; i < 3; i++) pushByte(0, BC);
    runAll();
    check("broken_three_more", {7'd0, active_0}, 8'h00);
    pushByte(0, BC);
    runAll();
    check("broken_relock", {7'd0, active_0}, 8'h01);

    $display("[TB] independent lanes");
    resetPulse(2);
    rise0 = -1; rise1 = -1; stb0cyc = -1; stb1cyc = -1;
    for (int i = 0; i < 4; i++) pushByte(0, BC);
    pushByte(0, 8'h11);
    pushByte(0, BC);
    for (int i = 0; i < 5; i++) pushBit(1, 1'b0);
    for (int i = 0; i < 4; i++) pushByte(1, BC);
    pushByte(1, 8'h22);
    pushByte(1, BC);
    runAll();
    checkInt("lane0_rise_seen", (rise0 > 0) ? 1 : 0, 1);
    checkInt("active_skew", rise1 - rise0, 5);
    checkInt("stb_skew", stb1cyc - stb0cyc, 5);
    check("indep_salida_0", salida_0, 8'h11);
    check("indep_salida_1", salida_1, 8'h22);

    $display("[TB] reset mid-operation");
    pushBit(0, 1'b1); pushBit(0, 1'b0); pushBit(0, 1'b1);
    runAll();
    resetPulse(2);
    check("midreset_active_0", {7'd0, active_0}, 8'h00);
    check("midreset_salida_1", salida_1, 8'h00);
    pushByte(0, 8'h5A);
    pushByte(0, 8'h5A);
    runAll();
    check("post_reset_ignored_valid", {7'd0, validout_0}, 8'h00);
    check("post_reset_ignored_active", {7'd0, active_0}, 8'h00);
    for (int i = 0; i < 4; i++) pushByte(0, BC);
    pushByte(0, 8'h33);
    runAll();
    check("relock_active_0", {7'd0, active_0}, 8'h01);
    check("relock_salida_0", salida_0, 8'h33);
    check("relock_stb_0", {7'd0, stb_0}, 8'h01);

    $display("[TB] random streams");
    for (int r = 0; r < 3; r++) begin
      resetPulse(1 + r);
      for (int l = 0; l < 2; l++) begin
        int junk;
        junk = $urandom_range(0, 7);
        for (int i = 0; i < junk; i++) pushBit(l, 1'($urandom));
        for (int i = 0; i < 4; i++) pushByte(l, BC);
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 2) == 0) pushByte(l, BC);
          else                           pushByte(l, 8'($urandom));
        end
        for (int i = 0; i < 20; i++) pushBit(l, 1'($urandom));
      end
      runAll();
    end
    for (int i = 0; i < 200; i++) applyStimulus(1'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
